// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch. Owns the PC, fetches words from
// instruction memory over a req/ack handshake, and holds the IF/ID register.
// A one-entry skid buffer absorbs a word that returns while ID is stalled.
// A taken Branch/Jump from the decoder redirects fetch and squashes the
// wrong-path instruction.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall                     hazard freeze of IF/ID (blocks redirects too)
//   branch, jump, zero        decoder/compare results for the ID instruction
//   br_offset, j_index        branch immediate (words) and jump index of ID
//   imem_req/addr/ack/rdata   instruction memory port (ack may be same cycle)
//   id_instr/id_pc4/id_valid  IF/ID pipeline register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic [31:0] br_offset,
  input  logic [25:0] j_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  // FETCH: normal issue. HOLD: skid buffer full, waiting for ID to drain.
  // KILL: a request is outstanding whose data belongs to a squashed path.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } state_e;

  // sll $0,$0,0 -- an R-type no-op, harmless if the decoder ever sees it.
  localparam logic [31:0] NOP = 32'h0000_0000;

  state_e      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] pending_q,  pending_d;
  logic [31:0] skid_q,     skid_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q,   id_pc4_d;
  logic        id_valid_q, id_valid_d;

  logic        taken;
  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // The upper two bits of the sign-extended offset fall off the <<2.
  logic        unused_offset_bits;
  assign unused_offset_bits = ^br_offset[31:30];

  assign pc_plus4 = pc_q + 32'd4;

  // Decoder raises Branch alongside Jump for j/jal, so jump must win.
  assign taken  = jump | (branch & zero);
  assign target = jump ? {id_pc4_q[31:28], j_index, 2'b00}
                       : id_pc4_q + {br_offset[29:0], 2'b00};

  // Only a real, advancing ID instruction may redirect.
  assign redir  = id_valid_q & ~stall & taken;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    skid_d     = skid_q;
    skid_pc4_d = skid_pc4_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;

    case (state_q)
      FETCH: begin
        if (redir) begin
          // Flush keeps id_pc4 so the next link/target math stays defined.
          id_valid_d = 1'b0;
          id_instr_d = NOP;
          if (imem_ack) begin
            pc_d = target;
          end else begin
            // Memory still owes us the wrong-path word; remember where to go.
            pending_d = target;
            state_d   = KILL;
          end
        end else if (imem_ack) begin
          pc_d = pc_plus4;
          if (!stall) begin
            id_instr_d = imem_rdata;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
          end else begin
            skid_d     = imem_rdata;
            skid_pc4_d = pc_plus4;
            state_d    = HOLD;
          end
        end else if (!stall) begin
          id_valid_d = 1'b0;
          id_instr_d = NOP;
        end
      end

      HOLD: begin
        if (!stall) begin
          state_d = FETCH;
          if (redir) begin
            // The skid word is the wrong path now.
            pc_d       = target;
            id_valid_d = 1'b0;
            id_instr_d = NOP;
          end else begin
            id_instr_d = skid_q;
            id_pc4_d   = skid_pc4_q;
            id_valid_d = 1'b1;
          end
        end
      end

      KILL: begin
        // id_valid is already 0 here, so no second redirect can arrive.
        if (imem_ack) begin
          pc_d    = pending_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      pending_q  <= 32'h0;
      skid_q     <= 32'h0;
      skid_pc4_q <= 32'h0;
      id_instr_q <= NOP;
      id_pc4_q   <= 32'h0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      skid_q     <= skid_d;
      skid_pc4_q <= skid_pc4_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Request is gated by rst directly so nothing is issued in the reset cycle.
  assign imem_req  = ~rst & (state_q != HOLD);
  assign imem_addr = pc_q;

  assign id_instr  = id_instr_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = id_valid_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the MIPS datapath, directly upstream of the main control decoder. Owns the PC, issues word reads to instruction memory over a req/ack handshake, and holds the IF/ID pipeline register whose instruction opcode feeds the control decoder. Consumes the decoder's `Branch`/`Jump` results (plus a zero flag) for the instruction in ID and redirects fetch, squashing the wrong-path instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard freeze: IF/ID holds, no redirect accepted.
- `branch`  in  1  decoder Branch for instruction in ID.
- `jump`  in  1  decoder Jump (asserted for both j and jal).
- `zero`  in  1  branch-compare equal flag for instruction in ID.
- `br_offset`  in  32  sign-extended 16-bit immediate of instruction in ID (word units).
- `j_index`  in  26  instr[25:0] of instruction in ID.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch byte address.
- `imem_ack`  in  1  read data valid this cycle; may be same cycle as request.
- `imem_rdata`  in  32  instruction word.
- `id_instr`  out  32  IF/ID instruction.
- `id_pc4`  out  32  IF/ID PC+4 (also link value for jal).
- `id_valid`  out  1  IF/ID holds a real instruction.

## Operation
- States: FETCH, HOLD (one-entry skid buffer full), KILL (outstanding request to be discarded).
- `imem_req` = !rst && state != HOLD. `imem_addr` = pc; pc stays stable while request outstanding.
- taken = jump | (branch & zero); target = jump ? {id_pc4[31:28], j_index, 2'b00} : id_pc4 + {br_offset[29:0], 2'b00}. Jump has priority over branch (decoder asserts Branch with Jump).
- redir = id_valid & !stall & taken.
- Bubble/flush: id_valid<=0, id_instr<=32'h0 (sll $0 nop, R-type, harmless), id_pc4 held.
- FETCH:
  - redir & ack: data discarded, pc<=target, flush, stay FETCH.
  - redir & !ack: pending<=target, flush, go KILL.
  - !redir & ack & !stall: id_instr<=rdata, id_pc4<=pc+4, id_valid<=1, pc<=pc+4.
  - !redir & ack & stall: skid<=rdata, skid_pc4<=pc+4, pc<=pc+4, go HOLD.
  - !redir & !ack & !stall: bubble.  !ack & stall: IF/ID holds.
- HOLD: stall -> stay. !stall & redir -> skid discarded, pc<=target, flush, FETCH. !stall & !redir -> IF/ID<=skid (valid 1), FETCH.
- KILL: request held at old pc; id_valid is 0 so no redirect possible. On ack: data discarded, pc<=pending, FETCH.
- Arithmetic mod 2^32; pc+4 from 32'hFFFF_FFFC wraps to 0. pc[1:0] always 00.

## Timing
- Reset (sync): pc=RESET_PC, state=FETCH, id_valid=0, id_instr=0, id_pc4=0, skid cleared; `imem_req`=0 during reset cycle, 1 first cycle after.
- Zero-wait memory: instruction at address A appears on id_* the cycle after A is requested; throughput 1 instr/cycle.
- Taken redirect: target requested the cycle after redir; exactly one bubble (zero-wait); with N-cycle memory, KILL costs remaining wait plus target fetch.
- Reset mid-KILL/HOLD: outstanding ack after reset is treated as answering the RESET_PC request (memory must drop requests on reset); skid contents lost.
- No instruction lost or duplicated across stall, skid, or wrap.

## Test plan
- RESET_PC=0x0040_0000, ack tied 1, no stall -> imem_addr 0x00400000, 0x00400004, ...; id_pc4=0x00400004 one cycle after first request, id_valid 1 thereafter.
- id_pc4=0x00400008, branch=zero=1, br_offset=0xFFFF_FFFE -> next imem_addr 0x00400000; one cycle id_valid=0, id_instr=0.
- jump=branch=1, zero=0, id_pc4=0x1000_0010, j_index=26'h100 -> next imem_addr 0x1000_0400.
- stall=1 for 3 cycles while ack arrives -> state HOLD, imem_req 0, IF/ID unchanged; stall release -> skid word on id_instr, next request at pc+4, sequence gap-free.
- redirect with ack delayed 3 cycles -> imem_addr held at old pc, returned word never reaches id_instr, then target requested.
- RESET_PC=0xFFFF_FFFC -> second imem_addr 0x0000_0000, first id_pc4=0.
